chiplet_mac_scheduler: RTL and testbench

- Time-shares one chiplet MAC engine among num_req_p requesters using round-robin arbitration.
- Each request carries a {id, size} workload word. The engine is held busy for the number of cycles that workload costs on num_macs_p MACs/cycle.
- It then emits a result word {id, macs_per_data_p} tagged with the requester index.
- Sits between per-layer input gathers and the output scatter stage of a chiplet performance model.

---
 rtl/chiplet_mac_scheduler_if.sv | 20 ++
 rtl/chiplet_mac_scheduler.sv | 108 ++++++++++
 tb/tb_chiplet_mac_scheduler.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/chiplet_mac_scheduler_if.sv
// Request/result bundle between the requesters, the MAC scheduler and the scatter stage.
interface chiplet_mac_scheduler_if #(
   parameter int unsigned num_req_p   = 4,
   parameter int unsigned width_p     = 24,
   parameter int unsigned tag_width_p = 2
);
   logic [num_req_p-1:0]              v_i;
   logic [num_req_p-1:0][width_p-1:0] data_i;
   logic [num_req_p-1:0]              yumi_o;
   logic                              v_o;
   logic [width_p-1:0]                data_o;
   logic [tag_width_p-1:0]            tag_o;
   logic                              ready_i;
   logic                              busy_o;

   modport master (output v_i, data_i, ready_i,
                   input  yumi_o, v_o, data_o, tag_o, busy_o);
   modport slave  (input  v_i, data_i, ready_i,
                   output yumi_o, v_o, data_o, tag_o, busy_o);
endinterface

// File: rtl/chiplet_mac_scheduler.sv
// Round-robin time-sharing of one chiplet MAC engine; holds the engine busy for
// ceil(size*macs_per_data/num_macs) cycles per workload, then emits a tagged result.
module chiplet_mac_scheduler #(
   parameter int unsigned num_req_p       = 4,
   parameter int unsigned id_width_p      = 8,
   parameter int unsigned size_width_p    = 16,
   parameter int unsigned num_macs_p      = 4,
   parameter int unsigned macs_per_data_p = 16,
   parameter int unsigned width_p         = id_width_p + size_width_p,
   parameter int unsigned tag_width_p     = (num_req_p > 1) ? $clog2(num_req_p) : 1,
   parameter int unsigned cycles_width_p  =
      size_width_p + ((macs_per_data_p > 1) ? $clog2(macs_per_data_p) : 1) + 1
) (
   input logic                    clk_i,
   input logic                    reset_i,
   chiplet_mac_scheduler_if.slave bus
);
   localparam int unsigned lg_macs_lp = $clog2(num_macs_p);

   typedef enum logic [1:0] {idle_s, busy_s, done_s} state_e;

   state_e                    state;
   logic [tag_width_p-1:0]    rr;
   logic [tag_width_p-1:0]    tag_q;
   logic [id_width_p-1:0]     id_q;
   logic [cycles_width_p-1:0] cnt;

   logic                      any_v;
   logic [tag_width_p-1:0]    gnt;
   logic [tag_width_p-1:0]    idx;
   logic [size_width_p-1:0]   size_c;
   logic [id_width_p-1:0]     id_c;
   logic [cycles_width_p-1:0] cycles_c;

   // First valid requester at or after the round-robin pointer, wrapping.
   always_comb begin
      any_v = 1'b0;
      gnt   = '0;
      idx   = '0;
      for (int unsigned i = 0; i < num_req_p; i++) begin
         idx = tag_width_p'((32'(rr) + i) % num_req_p);
         if (!any_v && bus.v_i[idx]) begin
            any_v = 1'b1;
            gnt   = idx;
         end
      end
   end

   assign size_c   = bus.data_i[gnt][size_width_p-1:0];
   assign id_c     = bus.data_i[gnt][width_p-1 -: id_width_p];
   assign cycles_c = (cycles_width_p'(size_c) * cycles_width_p'(macs_per_data_p)
                      + cycles_width_p'(num_macs_p - 1)) >> lg_macs_lp;

   // Accept is combinational so the requester sees consumption in the grant cycle.
   always_comb begin
      bus.yumi_o = '0;
      if (!reset_i && state == idle_s && any_v) bus.yumi_o[gnt] = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state      <= idle_s;
         rr         <= '0;
         cnt        <= '0;
         id_q       <= '0;
         tag_q      <= '0;
         bus.v_o    <= 1'b0;
         bus.data_o <= '0;
         bus.tag_o  <= '0;
         bus.busy_o <= 1'b0;
      end else begin
         unique case (state)
            idle_s: if (any_v) begin
               id_q       <= id_c;
               tag_q      <= gnt;
               rr         <= (32'(gnt) == num_req_p - 1) ? '0 : gnt + tag_width_p'(1);
               bus.busy_o <= 1'b1;
               if (cycles_c == '0) begin
                  state      <= done_s;
                  bus.v_o    <= 1'b1;
                  bus.data_o <= {id_c, size_width_p'(macs_per_data_p)};
                  bus.tag_o  <= gnt;
               end else begin
                  state <= busy_s;
                  cnt   <= cycles_c - cycles_width_p'(1);
               end
            end
            busy_s: if (cnt == '0) begin
               state      <= done_s;
               bus.v_o    <= 1'b1;
               bus.data_o <= {id_q, size_width_p'(macs_per_data_p)};
               bus.tag_o  <= tag_q;
            end else begin
               cnt <= cnt - cycles_width_p'(1);
            end
            // Result holds until taken; the handshake cycle is a deliberate bubble.
            done_s: if (bus.ready_i) begin
               state      <= idle_s;
               bus.v_o    <= 1'b0;
               bus.data_o <= '0;
               bus.tag_o  <= '0;
               bus.busy_o <= 1'b0;
            end
            default: state <= idle_s;
         endcase
      end
   end
endmodule

// File: tb/tb_chiplet_mac_scheduler.sv
// Bench for chiplet_mac_scheduler: directed scenarios plus random traffic against a
// transaction-level model (grant order, accept-to-result latency, result contents).
module tb_chiplet_mac_scheduler;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   chiplet_mac_scheduler_if #(.num_req_p(4), .width_p(24), .tag_width_p(2)) ifa ();
   chiplet_mac_scheduler_if #(.num_req_p(4), .width_p(24), .tag_width_p(2)) ifb ();

   chiplet_mac_scheduler dut_a (.clk_i(clk), .reset_i(reset), .bus(ifa));
   chiplet_mac_scheduler #(.macs_per_data_p(3)) dut_b (.clk_i(clk), .reset_i(reset), .bus(ifb));

   int unsigned total = 0;
   int unsigned bad   = 0;

   // Model state
   int unsigned cyc = 0;
   bit          in_flight = 1'b0;
   int unsigned done_cyc, hs_cyc, obs_lat;
   logic [7:0]  exp_id;
   int unsigned exp_tag;
   int unsigned rr_m = 0;
   bit          pend [4];
   logic [23:0] word [4];
   int          fixed_size = -1;
   bit          prev_v = 1'b0;
   int          last_gnt = -1;
   int unsigned gnt_log [$];
   int unsigned gnt_cyc [$];
   int          exp_ord [5] = '{0, 1, 2, 3, 0};
   int unsigned b_lat;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int unsigned ceil_cycles(input int unsigned size, input int unsigned mpd,
                                               input int unsigned nm);
      int unsigned c = 0;
      while (c * nm < size * mpd) c++;
      return c;
   endfunction

   function automatic int idx_of(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic bit any_pend();
      for (int i = 0; i < 4; i++) if (pend[i]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic issue(input int r, input logic [7:0] id, input logic [15:0] size);
      pend[r] = 1'b1;
      word[r] = {id, size};
   endtask

   // One cycle: refresh requests, drive, then compare DUT outputs with the model.
   task automatic tick(input int unsigned p_req, input int unsigned p_rdy);
      int         g;
      logic [3:0] ey;
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 4; i++) begin
         if (!pend[i] && $urandom_range(99) < p_req) begin
            pend[i] = 1'b1;
            if (fixed_size < 0) word[i] = {8'($urandom), 16'($urandom_range(7))};
            else                word[i] = {8'($urandom), 16'(fixed_size)};
         end
         ifa.v_i[i]    = pend[i];
         ifa.data_i[i] = pend[i] ? word[i] : 24'($urandom);
      end
      ifa.ready_i = ($urandom_range(99) < p_rdy);
      #1;
      if (ifa.yumi_o != '0) begin
         last_gnt = idx_of(ifa.yumi_o);
         gnt_log.push_back(last_gnt);
         gnt_cyc.push_back(cyc);
      end
      if (ifa.v_o && !prev_v && gnt_cyc.size() > 0) obs_lat = cyc - gnt_cyc[gnt_cyc.size()-1];
      prev_v = ifa.v_o;
      check("busy", ifa.busy_o, in_flight);
      if (in_flight && cyc >= done_cyc) begin
         check("v_o", ifa.v_o, 1);
         check("data_o", ifa.data_o, {exp_id, 16'd16});
         check("tag_o", ifa.tag_o, exp_tag);
         check("yumi_in_done", ifa.yumi_o, 0);
         if (ifa.ready_i) begin
            in_flight = 1'b0;
            hs_cyc    = cyc;
         end
      end else begin
         check("v_o_low", ifa.v_o, 0);
         check("data_o_zero", ifa.data_o, 0);
         check("tag_o_zero", ifa.tag_o, 0);
         g = -1;
         if (!in_flight)
            for (int k = 0; k < 4; k++)
               if (g < 0 && pend[(rr_m + k) % 4]) g = int'((rr_m + k) % 4);
         ey = '0;
         if (g >= 0) ey[g] = 1'b1;
         check("yumi", ifa.yumi_o, ey);
         if (g >= 0) begin
            exp_id    = word[g][23:16];
            exp_tag   = g;
            done_cyc  = cyc + ceil_cycles(word[g][15:0], 16, 4) + 1;
            rr_m      = (g + 1) % 4;
            pend[g]   = 1'b0;
            in_flight = 1'b1;
         end
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((in_flight || any_pend()) && n < 300) begin
         tick(0, 100);
         n++;
      end
      check("drain_done", n < 300, 1);
      tick(0, 100);
   endtask

   // Single job on the macs_per_data=3 instance; returns accept-to-v_o latency.
   task automatic run_b(input logic [15:0] size, input logic [7:0] id, output int unsigned lat);
      int unsigned n;
      @(negedge clk);
      ifb.v_i = 4'b0001; ifb.data_i[0] = {id, size}; ifb.ready_i = 1'b1;
      #1;
      check("b_yumi", ifb.yumi_o, 4'b0001);
      @(negedge clk);
      ifb.v_i = '0;
      n = 1;
      while (!ifb.v_o && n < 100) begin
         @(negedge clk);
         n++;
      end
      lat = n;
      check("b_lat", n, ceil_cycles(size, 3, 4) + 1);
      check("b_data", ifb.data_o, {id, 16'd3});
      check("b_tag", ifb.tag_o, 0);
      @(negedge clk);
      check("b_idle", ifb.busy_o, 0);
      check("b_v_low", ifb.v_o, 0);
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin pend[i] = 1'b0; word[i] = '0; end
      reset = 1'b1;
      ifa.v_i = 4'hF; ifa.data_i = '0; ifa.ready_i = 1'b0;
      ifb.v_i = '0;   ifb.data_i = '0; ifb.ready_i = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_v_o", ifa.v_o, 0);
      check("rst_data_o", ifa.data_o, 0);
      check("rst_tag_o", ifa.tag_o, 0);
      check("rst_busy", ifa.busy_o, 0);
      check("rst_yumi", ifa.yumi_o, 0);
      reset = 1'b0; ifa.v_i = '0;

      // Round-robin with all four requesters continuously valid
      fixed_size = 1;
      for (int k = 0; k < 4; k++) issue(k, 8'(8'h10 + k), 16'd1);
      for (int n = 0; n < 60 && gnt_log.size() < 5; n++) tick(100, 100);
      check("rr_count", gnt_log.size(), 5);
      for (int k = 0; k < 5; k++)
         if (k < gnt_log.size()) check("rr_order", gnt_log[k], exp_ord[k]);
      for (int k = 1; k < 5; k++)
         if (k < gnt_cyc.size()) check("rr_gap", gnt_cyc[k] - gnt_cyc[k-1], 6);
      fixed_size = -1;
      drain();

      // Single request, size 3: 12 busy cycles
      obs_lat = 0; last_gnt = -1;
      issue(0, 8'h05, 16'd3);
      drain();
      check("single_lat", obs_lat, 13);
      check("single_gnt", last_gnt, 0);

      // Zero-size workload
      obs_lat = 0; last_gnt = -1;
      issue(2, 8'hC3, 16'd0);
      drain();
      check("zero_lat", obs_lat, 1);
      check("zero_gnt", last_gnt, 2);

      // Backpressure: result held while another requester waits
      last_gnt = -1;
      issue(1, 8'h9A, 16'd2);
      repeat (4) tick(0, 0);
      issue(3, 8'h77, 16'd1);
      repeat (16) tick(0, 0);
      check("bp_no_grant", last_gnt, 1);
      tick(0, 100);
      tick(0, 100);
      check("bp_resume_gnt", last_gnt, 3);
      check("bp_resume_gap", gnt_cyc[gnt_cyc.size()-1] - hs_cyc, 1);
      drain();

      // Random traffic with random backpressure
      repeat (1500) tick(35, 60);
      drain();

      // Reset three cycles into a 12-cycle job
      issue(2, 8'hA7, 16'd3);
      repeat (4) tick(0, 100);
      @(negedge clk);
      reset = 1'b1; ifa.v_i = '0; ifa.ready_i = 1'b1;
      @(negedge clk);
      #1;
      check("mid_rst_v_o", ifa.v_o, 0);
      check("mid_rst_busy", ifa.busy_o, 0);
      check("mid_rst_data", ifa.data_o, 0);
      check("mid_rst_tag", ifa.tag_o, 0);
      reset = 1'b0;
      in_flight = 1'b0; rr_m = 0; prev_v = 1'b0;
      for (int i = 0; i < 4; i++) pend[i] = 1'b0;
      last_gnt = -1;
      issue(0, 8'h3C, 16'd1);
      issue(3, 8'h4D, 16'd1);
      tick(0, 100);
      check("post_rst_gnt", last_gnt, 0);
      drain();

      // Rounding on the macs_per_data=3 instance
      run_b(16'd5, 8'h21, b_lat);
      check("b_round_5", b_lat, 5);
      run_b(16'd0, 8'h22, b_lat);
      repeat (6) run_b(16'($urandom_range(40)), 8'($urandom), b_lat);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
